// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 32-byte lines.
// The word port sees zero-latency hits; misses stall while the block port
// writes back a dirty victim and then fills the requested line. A flush walk
// writes back every dirty line and invalidates the whole array.
module dcache_dm_wb #(
  parameter int NUM_LINES = 32,
  parameter int INDEX_W   = 5
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         read_2DC,
  input  logic         write_2DC,
  input  logic [31:0]  data_address_2DC,
  input  logic [31:0]  data_write_2DC,
  input  logic [1:0]   data_write_size_2DC,
  input  logic         flush_2DC,
  output logic [31:0]  data_read_fDC,
  output logic         data_valid_fDC,
  output logic         flush_done,
  output logic [31:0]  block_address_2DM,
  output logic         dBlkRead,
  output logic         dBlkWrite,
  input  logic [255:0] block_read_fDM,
  input  logic         block_read_fDM_valid,
  output logic [255:0] block_write_2DM,
  input  logic         block_write_fDM_valid
);

  localparam int TAG_W = 27 - INDEX_W;
  localparam logic [INDEX_W:0] PTR_ONE = (INDEX_W + 1)'(1);

  typedef enum logic [2:0] {IDLE, WB, FILL, FL_SCAN, FL_WB} state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [255:0]         line_q [NUM_LINES];
  logic [255:0]         line_d [NUM_LINES];
  logic [26:0]          req_blk_q, req_blk_d;
  logic [INDEX_W:0]     ptr_q, ptr_d;
  logic                 flush_armed_q, flush_armed_d;
  logic [31:0]          rdata_q, rdata_d;

  logic [INDEX_W-1:0]   req_index;
  logic [INDEX_W-1:0]   lat_index;
  logic [INDEX_W-1:0]   ptr_index;
  logic [TAG_W-1:0]     req_tag;
  logic [2:0]           req_word;
  logic                 req_hit;
  logic                 req_any;
  logic [31:0]          hit_word;

  assign req_index = data_address_2DC[4+INDEX_W:5];
  assign req_tag   = data_address_2DC[31:5+INDEX_W];
  assign req_word  = data_address_2DC[4:2];
  assign lat_index = req_blk_q[INDEX_W-1:0];
  assign ptr_index = ptr_q[INDEX_W-1:0];
  assign req_hit   = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign req_any   = read_2DC || write_2DC;
  assign hit_word  = line_q[req_index][{req_word, 5'b0} +: 32];

  // Place the low 'size' bytes of wdata big-endian starting at byte offset;
  // bytes that would run past the end of the word are discarded.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  byte_off);
    logic [31:0] result;
    int          nb;
    int          pos;
    result = old_word;
    nb     = (size == 2'd0) ? 4 : int'(size);
    for (int k = 0; k < 4; k++) begin
      pos = int'(byte_off) + k;
      if (k < nb && pos <= 3) begin
        result[8*(3-pos) +: 8] = wdata[8*(nb-1-k) +: 8];
      end
    end
    return result;
  endfunction

  // Next-state, array updates and all port outputs for the controller.
  always_comb begin
    state_d           = state_q;
    valid_d           = valid_q;
    dirty_d           = dirty_q;
    tag_d             = tag_q;
    line_d            = line_q;
    req_blk_d         = req_blk_q;
    ptr_d             = ptr_q;
    flush_armed_d     = flush_armed_q;
    rdata_d           = rdata_q;
    data_read_fDC     = rdata_q;
    data_valid_fDC    = 1'b0;
    flush_done        = 1'b0;
    block_address_2DM = 32'h0;
    dBlkRead          = 1'b0;
    dBlkWrite         = 1'b0;
    block_write_2DM   = '0;

    if (!flush_2DC) begin
      flush_armed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (flush_2DC && flush_armed_q) begin
          flush_armed_d = 1'b0;
          ptr_d         = '0;
          state_d       = FL_SCAN;
        end else if (req_any) begin
          if (req_hit) begin
            data_valid_fDC = 1'b1;
            if (write_2DC) begin
              line_d[req_index][{req_word, 5'b0} +: 32] =
                merge_word(hit_word, data_write_2DC, data_write_size_2DC,
                           data_address_2DC[1:0]);
              dirty_d[req_index] = 1'b1;
            end else begin
              data_read_fDC = hit_word;
              rdata_d       = hit_word;
            end
          end else begin
            req_blk_d = data_address_2DC[31:5];
            if (valid_q[req_index] && dirty_q[req_index]) begin
              state_d = WB;
            end else begin
              state_d = FILL;
            end
          end
        end
      end

      WB: begin
        dBlkWrite         = 1'b1;
        block_address_2DM = {tag_q[lat_index], lat_index, 5'b0};
        block_write_2DM   = line_q[lat_index];
        if (block_write_fDM_valid) begin
          state_d = FILL;
        end
      end

      FILL: begin
        dBlkRead          = 1'b1;
        block_address_2DM = {req_blk_q, 5'b0};
        if (block_read_fDM_valid) begin
          line_d[lat_index]  = block_read_fDM;
          tag_d[lat_index]   = req_blk_q[26:INDEX_W];
          valid_d[lat_index] = 1'b1;
          dirty_d[lat_index] = 1'b0;
          state_d            = IDLE;
        end
      end

      FL_SCAN: begin
        if (ptr_q[INDEX_W]) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end else if (valid_q[ptr_index] && dirty_q[ptr_index]) begin
          state_d = FL_WB;
        end else begin
          valid_d[ptr_index] = 1'b0;
          ptr_d              = ptr_q + PTR_ONE;
        end
      end

      FL_WB: begin
        dBlkWrite         = 1'b1;
        block_address_2DM = {tag_q[ptr_index], ptr_index, 5'b0};
        block_write_2DM   = line_q[ptr_index];
        if (block_write_fDM_valid) begin
          valid_d[ptr_index] = 1'b0;
          dirty_d[ptr_index] = 1'b0;
          ptr_d              = ptr_q + PTR_ONE;
          state_d            = FL_SCAN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (RESET) begin
      data_read_fDC     = 32'h0;
      data_valid_fDC    = 1'b0;
      flush_done        = 1'b0;
      block_address_2DM = 32'h0;
      dBlkRead          = 1'b0;
      dBlkWrite         = 1'b0;
      block_write_2DM   = '0;
    end
  end

  // Control state, valid/dirty bits and the held read word, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      dirty_q       <= '0;
      req_blk_q     <= '0;
      ptr_q         <= '0;
      flush_armed_q <= 1'b1;
      rdata_q       <= 32'h0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      dirty_q       <= dirty_d;
      req_blk_q     <= req_blk_d;
      ptr_q         <= ptr_d;
      flush_armed_q <= flush_armed_d;
      rdata_q       <= rdata_d;
    end
  end

  // Tag and data arrays need no reset since valid bits gate their use.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    line_q <= line_d;
  end

endmodule
